// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared sizes, entry record and helper functions for
// the reorder buffer and its pointer sub-module.
//   ROB_DEPTH : physical slots (slot 0 is reserved as the "no dependency" tag)
//   ROB_AW    : ROB id width
//   REG_AW    : architectural register address width
//   DATA_W    : register data width
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_AW    = 4;
  localparam int REG_AW    = 5;
  localparam int DATA_W    = 32;

  typedef logic [ROB_AW-1:0] rob_id_t;
  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    logic      done;
    reg_addr_t addr;
    reg_data_t data;
  } rob_entry_t;

  // Pointer increment over 1..ROB_DEPTH-1; id 0 is never produced.
  function automatic rob_id_t rob_next(input rob_id_t p);
    return (p == rob_id_t'(ROB_DEPTH - 1)) ? rob_id_t'(1) : p + rob_id_t'(1);
  endfunction

  // Operand lookup: returns {rdy, data}. A live CDB broadcast of the tag
  // wins over the stored entry so the dispatcher sees results one cycle early.
  function automatic logic [DATA_W:0] rob_query(input rob_id_t    id,
                                                input logic       cdb_en,
                                                input rob_id_t    cdb_id,
                                                input reg_data_t  cdb_data,
                                                input rob_entry_t ent);
    if (id == rob_id_t'(0))                return {1'b0, {DATA_W{1'b0}}};
    else if (cdb_en && (cdb_id == id))     return {1'b1, cdb_data};
    else if (ent.valid && ent.done)        return {1'b1, ent.data};
    else                                   return {1'b0, {DATA_W{1'b0}}};
  endfunction

endpackage

// File: rtl/reorder_buffer_ptr.sv
// rob_ptr: wrapping ROB pointer register used for head and tail.
//   clk, rst  : clock, synchronous active-high reset (pointer -> 1)
//   rdy_i     : global enable, low holds the pointer
//   clr_i     : return pointer to 1 (flush), wins over inc_i
//   inc_i     : advance pointer, wrapping ROB_DEPTH-1 -> 1
//   ptr_o     : current pointer value
module rob_ptr
  import reorder_buffer_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy_i,
  input  logic    clr_i,
  input  logic    inc_i,
  output rob_id_t ptr_o
);

  rob_id_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = rob_id_t'(1);
    else if (inc_i) ptr_d = rob_next(ptr_q);
  end

  always_ff @(posedge clk) begin
    if (rst)        ptr_q <= rob_id_t'(1);
    else if (rdy_i) ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer between dispatcher, CDB and
// register file. Build option: define ROB_FWD_EN to build the q1/q2 operand
// query logic (with CDB bypass); otherwise the query outputs are tied to 0.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rdy                   : global enable; low freezes all state and w* outputs
//   allocEn_i/allocAddr_i : allocate one entry for destination register
//   allocId_o, full_o     : id the next allocation receives, no free entry
//   cdbEn_i/cdbId_i/cdbData_i : result broadcast from execution units
//   q1Id_i/q2Id_i -> q*Rdy_o/q*Data_o : operand availability lookup
//   flush_i               : discard all entries
//   wEn_o/wId_o/wAddr_o/wData_o : registered commit write to register file
//
// Allocation handshake: allocEn_i is the request and !full_o is the accept;
// an entry is taken on a rising edge only when allocEn_i && !full_o && rdy,
// and a request while full is dropped, not held.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              allocEn_i,
  input  logic [REG_AW-1:0] allocAddr_i,
  output logic [ROB_AW-1:0] allocId_o,
  output logic              full_o,
  input  logic              cdbEn_i,
  input  logic [ROB_AW-1:0] cdbId_i,
  input  logic [DATA_W-1:0] cdbData_i,
  input  logic [ROB_AW-1:0] q1Id_i,
  input  logic [ROB_AW-1:0] q2Id_i,
  output logic              q1Rdy_o,
  output logic              q2Rdy_o,
  output logic [DATA_W-1:0] q1Data_o,
  output logic [DATA_W-1:0] q2Data_o,
  input  logic              flush_i,
  output logic              wEn_o,
  output logic [ROB_AW-1:0] wId_o,
  output logic [REG_AW-1:0] wAddr_o,
  output logic [DATA_W-1:0] wData_o
);

  rob_entry_t ent_q [ROB_DEPTH];
  rob_entry_t ent_d [ROB_DEPTH];
  rob_id_t    count_q, count_d;
  rob_id_t    head, tail;
  logic       w_en_q, w_en_d;
  rob_id_t    w_id_q, w_id_d;
  reg_addr_t  w_addr_q, w_addr_d;
  reg_data_t  w_data_q, w_data_d;

  logic alloc_fire, commit_fire, cdb_hit;

  assign full_o    = (count_q == rob_id_t'(ROB_DEPTH - 1));
  assign allocId_o = tail;

  // Decisions use registered entry state only: a CDB write to the entry being
  // allocated this cycle sees valid=0 and is dropped, and a result written on
  // this edge cannot commit until the next one.
  assign alloc_fire  = allocEn_i && !full_o && !flush_i;
  assign commit_fire = ent_q[head].valid && ent_q[head].done && !flush_i;
  assign cdb_hit     = cdbEn_i && (cdbId_i != rob_id_t'(0)) &&
                       ent_q[cdbId_i].valid && !flush_i;

  rob_ptr u_head (
    .clk   (clk),
    .rst   (rst),
    .rdy_i (rdy),
    .clr_i (flush_i),
    .inc_i (commit_fire),
    .ptr_o (head)
  );

  rob_ptr u_tail (
    .clk   (clk),
    .rst   (rst),
    .rdy_i (rdy),
    .clr_i (flush_i),
    .inc_i (alloc_fire),
    .ptr_o (tail)
  );

  always_comb begin
    ent_d    = ent_q;
    count_d  = count_q;
    w_en_d   = 1'b0;
    w_id_d   = w_id_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (flush_i) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].done  = 1'b0;
      end
      count_d = rob_id_t'(0);
    end else begin
      if (cdb_hit) begin
        ent_d[cdbId_i].done = 1'b1;
        ent_d[cdbId_i].data = cdbData_i;
      end
      if (alloc_fire) begin
        ent_d[tail].valid = 1'b1;
        ent_d[tail].done  = 1'b0;
        ent_d[tail].addr  = allocAddr_i;
      end
      if (commit_fire) begin
        ent_d[head].valid = 1'b0;
        ent_d[head].done  = 1'b0;
        // Writes to r0 retire silently.
        w_en_d   = (ent_q[head].addr != reg_addr_t'(0));
        w_id_d   = head;
        w_addr_d = ent_q[head].addr;
        w_data_d = ent_q[head].data;
      end
      count_d = count_q + rob_id_t'(alloc_fire) - rob_id_t'(commit_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= '0;
      count_q  <= '0;
      w_en_q   <= 1'b0;
      w_id_q   <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else if (rdy) begin
      ent_q    <= ent_d;
      count_q  <= count_d;
      w_en_q   <= w_en_d;
      w_id_q   <= w_id_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign wEn_o   = w_en_q;
  assign wId_o   = w_id_q;
  assign wAddr_o = w_addr_q;
  assign wData_o = w_data_q;

`ifdef ROB_FWD_EN
  assign {q1Rdy_o, q1Data_o} = rob_query(q1Id_i, cdbEn_i, cdbId_i, cdbData_i, ent_q[q1Id_i]);
  assign {q2Rdy_o, q2Data_o} = rob_query(q2Id_i, cdbEn_i, cdbId_i, cdbData_i, ent_q[q2Id_i]);
`else
  // Operands wait for commit through the register file.
  logic unused_q_ids;
  assign unused_q_ids = ^{q1Id_i, q2Id_i};
  assign q1Rdy_o  = 1'b0;
  assign q2Rdy_o  = 1'b0;
  assign q1Data_o = '0;
  assign q2Data_o = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed bench for reorder_buffer. Inputs change #1
// after a rising edge; registered outputs are sampled there too, and
// combinational outputs are sampled just before the next edge.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        allocEn_i;
  logic [4:0]  allocAddr_i;
  logic [3:0]  allocId_o;
  logic        full_o;
  logic        cdbEn_i;
  logic [3:0]  cdbId_i;
  logic [31:0] cdbData_i;
  logic [3:0]  q1Id_i, q2Id_i;
  logic        q1Rdy_o, q2Rdy_o;
  logic [31:0] q1Data_o, q2Data_o;
  logic        flush_i;
  logic        wEn_o;
  logic [3:0]  wId_o;
  logic [4:0]  wAddr_o;
  logic [31:0] wData_o;

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef ROB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .allocEn_i(allocEn_i), .allocAddr_i(allocAddr_i),
    .allocId_o(allocId_o), .full_o(full_o),
    .cdbEn_i(cdbEn_i), .cdbId_i(cdbId_i), .cdbData_i(cdbData_i),
    .q1Id_i(q1Id_i), .q2Id_i(q2Id_i),
    .q1Rdy_o(q1Rdy_o), .q2Rdy_o(q2Rdy_o),
    .q1Data_o(q1Data_o), .q2Data_o(q2Data_o),
    .flush_i(flush_i),
    .wEn_o(wEn_o), .wId_o(wId_o), .wAddr_o(wAddr_o), .wData_o(wData_o)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    allocEn_i = 1'b0; allocAddr_i = '0;
    cdbEn_i = 1'b0; cdbId_i = '0; cdbData_i = '0;
    q1Id_i = '0; q2Id_i = '0; flush_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vec_cnt++; if (wEn_o !== 1'b0) begin err_cnt++; $display("FAIL reset_wen: got %0h want 0", wEn_o); end
    vec_cnt++; if (wId_o !== 4'd0) begin err_cnt++; $display("FAIL reset_wid: got %0h want 0", wId_o); end
    vec_cnt++; if (wAddr_o !== 5'd0) begin err_cnt++; $display("FAIL reset_waddr: got %0h want 0", wAddr_o); end
    vec_cnt++; if (wData_o !== 32'd0) begin err_cnt++; $display("FAIL reset_wdata: got %0h want 0", wData_o); end
    vec_cnt++; if (full_o !== 1'b0) begin err_cnt++; $display("FAIL reset_full: got %0h want 0", full_o); end
    vec_cnt++; if (allocId_o !== 4'd1) begin err_cnt++; $display("FAIL reset_allocid: got %0h want 1", allocId_o); end
    vec_cnt++; if (dut.count_q !== 4'd0) begin err_cnt++; $display("FAIL reset_count: got %0h want 0", dut.count_q); end
  endtask

  task automatic test_alloc();
    logic [4:0] addrs [3];
    addrs[0] = 5'd5; addrs[1] = 5'd0; addrs[2] = 5'd7;
    for (int i = 0; i < 3; i++) begin
      allocEn_i = 1'b1; allocAddr_i = addrs[i];
      #3;
      vec_cnt++;
      if (allocId_o !== 4'(i + 1)) begin err_cnt++; $display("FAIL alloc_id%0d: got %0h want %0h", i, allocId_o, i + 1); end
      tick();
    end
    allocEn_i = 1'b0;
    vec_cnt++; if (dut.count_q !== 4'd3) begin err_cnt++; $display("FAIL alloc_count: got %0h want 3", dut.count_q); end
    vec_cnt++; if (allocId_o !== 4'd4) begin err_cnt++; $display("FAIL alloc_next: got %0h want 4", allocId_o); end
  endtask

  task automatic test_cdb_commit();
    cdbEn_i = 1'b1; cdbId_i = 4'd2; cdbData_i = 32'h22;
    tick();
    vec_cnt++; if (wEn_o !== 1'b0) begin err_cnt++; $display("FAIL cdb2_nocommit: got %0h want 0", wEn_o); end
    cdbId_i = 4'd1; cdbData_i = 32'h11;
    tick();
    cdbEn_i = 1'b0;
    // id 1 completed on this edge; no bypass into commit
    vec_cnt++; if (wEn_o !== 1'b0) begin err_cnt++; $display("FAIL cdb1_nobypass: got %0h want 0", wEn_o); end
    tick();
    vec_cnt++; if (wEn_o !== 1'b1) begin err_cnt++; $display("FAIL c1_wen: got %0h want 1", wEn_o); end
    vec_cnt++; if (wId_o !== 4'd1) begin err_cnt++; $display("FAIL c1_wid: got %0h want 1", wId_o); end
    vec_cnt++; if (wAddr_o !== 5'd5) begin err_cnt++; $display("FAIL c1_waddr: got %0h want 5", wAddr_o); end
    vec_cnt++; if (wData_o !== 32'h11) begin err_cnt++; $display("FAIL c1_wdata: got %0h want 11", wData_o); end
    tick();
    vec_cnt++; if (wEn_o !== 1'b0) begin err_cnt++; $display("FAIL c2_wen_r0: got %0h want 0", wEn_o); end
    vec_cnt++; if (wId_o !== 4'd2) begin err_cnt++; $display("FAIL c2_wid: got %0h want 2", wId_o); end
    vec_cnt++; if (wData_o !== 32'h22) begin err_cnt++; $display("FAIL c2_wdata: got %0h want 22", wData_o); end
    tick();
    vec_cnt++; if (wEn_o !== 1'b0) begin err_cnt++; $display("FAIL c3_pending_wen: got %0h want 0", wEn_o); end
    vec_cnt++; if (wId_o !== 4'd2) begin err_cnt++; $display("FAIL c3_hold_wid: got %0h want 2", wId_o); end
    vec_cnt++; if (dut.count_q !== 4'd1) begin err_cnt++; $display("FAIL c3_count: got %0h want 1", dut.count_q); end
  endtask

  task automatic test_query();
    // id 3 pending; CDB broadcasts it this cycle
    q1Id_i = 4'd3; q2Id_i = 4'd0;
    cdbEn_i = 1'b1; cdbId_i = 4'd3; cdbData_i = 32'hABCD;
    #3;
    vec_cnt++; if (q1Rdy_o !== FWD) begin err_cnt++; $display("FAIL q1_bypass_rdy: got %0h want %0h", q1Rdy_o, FWD); end
    vec_cnt++; if (q1Data_o !== (FWD ? 32'hABCD : 32'h0)) begin err_cnt++; $display("FAIL q1_bypass_data: got %0h want %0h", q1Data_o, FWD ? 32'hABCD : 32'h0); end
    vec_cnt++; if (q2Rdy_o !== 1'b0) begin err_cnt++; $display("FAIL q2_id0_rdy: got %0h want 0", q2Rdy_o); end
    tick();
    cdbEn_i = 1'b0; cdbData_i = 32'h0;
    #3;
    vec_cnt++; if (q1Rdy_o !== FWD) begin err_cnt++; $display("FAIL q1_stored_rdy: got %0h want %0h", q1Rdy_o, FWD); end
    vec_cnt++; if (q1Data_o !== (FWD ? 32'hABCD : 32'h0)) begin err_cnt++; $display("FAIL q1_stored_data: got %0h want %0h", q1Data_o, FWD ? 32'hABCD : 32'h0); end
    tick();
    vec_cnt++; if (wEn_o !== 1'b1) begin err_cnt++; $display("FAIL c3_wen: got %0h want 1", wEn_o); end
    vec_cnt++; if (wAddr_o !== 5'd7) begin err_cnt++; $display("FAIL c3_waddr: got %0h want 7", wAddr_o); end
    vec_cnt++; if (wData_o !== 32'hABCD) begin err_cnt++; $display("FAIL c3_wdata: got %0h want abcd", wData_o); end
    vec_cnt++; if (q1Rdy_o !== 1'b0) begin err_cnt++; $display("FAIL q1_retired_rdy: got %0h want 0", q1Rdy_o); end
    q1Id_i = 4'd0;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      allocEn_i = 1'b1; allocAddr_i = 5'(i);
      #3;
      vec_cnt++;
      if (allocId_o !== 4'(i)) begin err_cnt++; $display("FAIL full_allocid%0d: got %0h want %0h", i, allocId_o, i); end
      tick();
    end
    // 16th request while full
    #3;
    vec_cnt++; if (full_o !== 1'b1) begin err_cnt++; $display("FAIL full_flag: got %0h want 1", full_o); end
    vec_cnt++; if (allocId_o !== 4'd1) begin err_cnt++; $display("FAIL full_wrap_id: got %0h want 1", allocId_o); end
    tick();
    allocEn_i = 1'b0;
    vec_cnt++; if (dut.count_q !== 4'd15) begin err_cnt++; $display("FAIL full_ignored_count: got %0h want f", dut.count_q); end
    vec_cnt++; if (full_o !== 1'b1) begin err_cnt++; $display("FAIL full_ignored_flag: got %0h want 1", full_o); end
    // retire id 1
    cdbEn_i = 1'b1; cdbId_i = 4'd1; cdbData_i = 32'h1111;
    tick();
    cdbEn_i = 1'b0;
    tick();
    vec_cnt++; if (wEn_o !== 1'b1) begin err_cnt++; $display("FAIL full_c1_wen: got %0h want 1", wEn_o); end
    vec_cnt++; if (wId_o !== 4'd1) begin err_cnt++; $display("FAIL full_c1_wid: got %0h want 1", wId_o); end
    vec_cnt++; if (full_o !== 1'b0) begin err_cnt++; $display("FAIL full_after_commit: got %0h want 0", full_o); end
    vec_cnt++; if (allocId_o !== 4'd1) begin err_cnt++; $display("FAIL full_next_id: got %0h want 1", allocId_o); end
    // refill slot 1 while completing id 2
    allocEn_i = 1'b1; allocAddr_i = 5'd20;
    cdbEn_i = 1'b1; cdbId_i = 4'd2; cdbData_i = 32'h2222;
    tick();
    cdbEn_i = 1'b0;
    vec_cnt++; if (full_o !== 1'b1) begin err_cnt++; $display("FAIL refill_full: got %0h want 1", full_o); end
    vec_cnt++; if (allocId_o !== 4'd2) begin err_cnt++; $display("FAIL refill_id: got %0h want 2", allocId_o); end
    // commit id 2 with an alloc request while full: alloc blocked
    tick();
    allocEn_i = 1'b0;
    vec_cnt++; if (wEn_o !== 1'b1) begin err_cnt++; $display("FAIL c2_full_wen: got %0h want 1", wEn_o); end
    vec_cnt++; if (wId_o !== 4'd2) begin err_cnt++; $display("FAIL c2_full_wid: got %0h want 2", wId_o); end
    vec_cnt++; if (wData_o !== 32'h2222) begin err_cnt++; $display("FAIL c2_full_wdata: got %0h want 2222", wData_o); end
    vec_cnt++; if (dut.count_q !== 4'd14) begin err_cnt++; $display("FAIL c2_full_count: got %0h want e", dut.count_q); end
    vec_cnt++; if (allocId_o !== 4'd2) begin err_cnt++; $display("FAIL c2_full_allocid: got %0h want 2", allocId_o); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      allocEn_i = 1'b1; allocAddr_i = 5'(i);
      tick();
    end
    allocEn_i = 1'b0;
    cdbEn_i = 1'b1; cdbId_i = 4'd3; cdbData_i = 32'h33;
    tick();
    cdbId_i = 4'd4; cdbData_i = 32'h44;
    tick();
    // flush with same-cycle alloc and a CDB completing the head
    flush_i = 1'b1; allocEn_i = 1'b1; allocAddr_i = 5'd9;
    cdbId_i = 4'd1; cdbData_i = 32'h11;
    tick();
    idle_inputs();
    vec_cnt++; if (wEn_o !== 1'b0) begin err_cnt++; $display("FAIL flush_wen: got %0h want 0", wEn_o); end
    vec_cnt++; if (dut.count_q !== 4'd0) begin err_cnt++; $display("FAIL flush_count: got %0h want 0", dut.count_q); end
    vec_cnt++; if (allocId_o !== 4'd1) begin err_cnt++; $display("FAIL flush_allocid: got %0h want 1", allocId_o); end
    tick(); tick();
    vec_cnt++; if (wEn_o !== 1'b0) begin err_cnt++; $display("FAIL flush_after_wen: got %0h want 0", wEn_o); end
    vec_cnt++; if (wId_o !== 4'd0) begin err_cnt++; $display("FAIL flush_after_wid: got %0h want 0", wId_o); end
  endtask

  task automatic test_rdy_stall();
    do_reset();
    allocEn_i = 1'b1; allocAddr_i = 5'd9;
    tick();
    allocEn_i = 1'b0;
    cdbEn_i = 1'b1; cdbId_i = 4'd1; cdbData_i = 32'h99;
    tick();
    cdbEn_i = 1'b0;
    // head done; freeze for 3 edges with an alloc request pending
    rdy = 1'b0; allocEn_i = 1'b1; allocAddr_i = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++; if (wEn_o !== 1'b0) begin err_cnt++; $display("FAIL stall_wen%0d: got %0h want 0", i, wEn_o); end
      vec_cnt++; if (wId_o !== 4'd0) begin err_cnt++; $display("FAIL stall_wid%0d: got %0h want 0", i, wId_o); end
      vec_cnt++; if (allocId_o !== 4'd2) begin err_cnt++; $display("FAIL stall_allocid%0d: got %0h want 2", i, allocId_o); end
    end
    rdy = 1'b1; allocEn_i = 1'b0;
    tick();
    vec_cnt++; if (wEn_o !== 1'b1) begin err_cnt++; $display("FAIL resume_wen: got %0h want 1", wEn_o); end
    vec_cnt++; if (wId_o !== 4'd1) begin err_cnt++; $display("FAIL resume_wid: got %0h want 1", wId_o); end
    vec_cnt++; if (wAddr_o !== 5'd9) begin err_cnt++; $display("FAIL resume_waddr: got %0h want 9", wAddr_o); end
    vec_cnt++; if (wData_o !== 32'h99) begin err_cnt++; $display("FAIL resume_wdata: got %0h want 99", wData_o); end
    vec_cnt++; if (dut.count_q !== 4'd0) begin err_cnt++; $display("FAIL resume_count: got %0h want 0", dut.count_q); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    rdy = 1'b1;
    test_reset();
    test_alloc();
    test_cdb_commit();
    test_query();
    test_full();
    test_flush();
    test_rdy_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer between the dispatcher, the common data bus (CDB) and the register file. The dispatcher allocates one entry per issued instruction and receives the entry's ROB id, which it forwards to the register file as the rename tag. Execution units post results to the entry over the CDB. The buffer retires completed head entries, one per cycle, as register-file writes (`wEn`/`wId`/`wAddr`/`wData`).

## Interface
- `ROB_DEPTH`, 16 — physical slots; id 0 is reserved as "no dependency", so usable ids are 1..ROB_DEPTH-1 (capacity 15).
- `ROB_AW`, 4 — id width, clog2(ROB_DEPTH), equals `ROBAddrBus` width.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high.
- `rdy` in 1 — global enable; low freezes all state and registered outputs.
- `allocEn_i` in 1 — dispatcher allocates one entry this cycle.
- `allocAddr_i` in 5 — destination register; 0 = no register result.
- `allocId_o` out ROB_AW — id the next allocation receives (combinational).
- `full_o` out 1 — no free entry (combinational).
- `cdbEn_i` in 1 — result valid.
- `cdbId_i` in ROB_AW — producing entry.
- `cdbData_i` in 32 — result value.
- `q1Id_i`, `q2Id_i` in ROB_AW each — operand tags queried by the dispatcher.
- `q1Rdy_o`, `q2Rdy_o` out 1 each — tagged value available.
- `q1Data_o`, `q2Data_o` out 32 each — tagged value.
- `flush_i` in 1 — discard all entries (mispredict or exception).
- `wEn_o` out 1 — commit write to the register file.
- `wId_o` out ROB_AW — committing id.
- `wAddr_o` out 5 — committing destination register.
- `wData_o` out 32 — committing value.

## Operation
- Per entry: `valid`, `done`, `addr[4:0]`, `data[31:0]`.
- Head and tail pointers range over 1..ROB_DEPTH-1. The increment after ROB_DEPTH-1 wraps to 1, never 0.
- `count` runs 0..ROB_DEPTH-1. `full_o` = (`count` == ROB_DEPTH-1). `allocId_o` = `tail`.
- Allocate: when `allocEn_i` && !`full_o` && `rdy`, the tail entry gets `valid`=1, `done`=0, `addr`=`allocAddr_i`, and tail advances. `allocEn_i` while full is ignored.
- CDB: when `cdbEn_i` and entry `cdbId_i` is valid, set `done`=1 and `data`=`cdbData_i`. A CDB write to an invalid entry or to id 0 is ignored.
- Commit: when the head entry is valid and done, on that edge clear the head entry, advance head, and register `wId_o`/`wAddr_o`/`wData_o`. `wEn_o`=1 for one cycle, except `wEn_o`=0 when `addr`==0 (the entry still retires).
- At most one commit per cycle. When there is no commit, `wEn_o`=0 and the other w outputs hold.
- Operand query, for each of q1/q2 (combinational):
  - id 0 → `Rdy`=0, `Data`=0.
  - else if the CDB is broadcasting that id this cycle → `Rdy`=1, `Data`=`cdbData_i`.
  - else if the entry is valid and done → `Rdy`=1, `Data`=entry data.
  - else `Rdy`=0, `Data`=0.
- Flush (`flush_i` && `rdy`): all `valid`=0, head=tail=1, `count`=0, `wEn_o`=0. Same-cycle alloc, CDB and commit are discarded.
- Priority: `rst` > !`rdy` > `flush_i` > {commit, alloc, CDB}.

## Timing
- Reset values: head=tail=1, `count`=0, all `valid`=0, `wEn_o`=0, `wId_o`=0, `wAddr_o`=0, `wData_o`=0, `full_o`=0, `allocId_o`=1.
- Alloc→CDB: a CDB write is accepted from the cycle after allocation. A same-cycle CDB write to the id being allocated is ignored.
- CDB→commit: no bypass. An entry completed on edge N can commit on edge N+1, with `wEn_o` visible after N+1.
- Alloc and commit in the same cycle: `count` unchanged. This is legal when full, but `full_o` still blocks the alloc in that cycle.
- The register file sees `wEn_o` one cycle after the commit decision and performs its write on the following edge.
- Query outputs are purely combinational from `q*Id_i`, entry state and the CDB.

## Configuration
- `ROB_FWD_EN` defined: the q1/q2 query logic, including the CDB bypass, is built as described above.
- `ROB_FWD_EN` undefined: the query ports remain, `q*Rdy_o`=0 and `q*Data_o`=0 constantly, and operands wait for commit through the register file.

## Structure
- `ROBAddrBus`, `RegAddrBus`, `RegBus` and `ROB_DEPTH` live in `define.v`, shared with the dispatcher and register file.
- One sub-module, `rob_ptr`: a wrapping pointer register (reset to 1, skips 0, increment enable), instantiated for head and tail.

## Test plan
- Reset, allocate 3 entries (addr 5, 0, 7) → `allocId_o` returns 1, 2, 3; `count`=3.
- CDB id 2 data 0x22, then id 1 data 0x11:
  - commit cycle 1: `wEn_o`=1, `wId_o`=1, `wAddr_o`=5, `wData_o`=0x11.
  - next cycle: id 2 retires with `wEn_o`=0.
  - id 3 stays pending.
- Allocate 15 entries → `full_o`=1. A 16th `allocEn_i` is ignored. Commit one → next `allocId_o` wraps to 1, never 0.
- `q1Id_i`=3 while the CDB broadcasts id 3 data 0xABCD → `q1Rdy_o`=1, `q1Data_o`=0xABCD the same cycle. With `ROB_FWD_EN` undefined → `q1Rdy_o`=0.
- `flush_i` with 4 entries, 2 done → no `wEn_o`; `count`=0; `allocId_o`=1.
- `rdy`=0 for 3 cycles with the head done → no commit and all outputs held. Commit occurs on the first `rdy`=1 edge.
